// File: rtl/cordic_cos_scheduler.sv
// cordic_cos_scheduler
// Shares one pipelined cosine CORDIC datapath among NUM_REQ requesters.
// A round-robin arbiter issues at most one angle per cycle, a tag pipe that
// runs alongside the datapath remembers who asked for each result, and the
// result is handed back as a one-cycle response strobe tagged with that ID.
// The datapath clock enable is only dropped when nothing is in flight,
// because deasserting it clears the datapath registers.

module cordic_cos_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [32*NUM_REQ-1:0] req_angle,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic                  flush,
    output logic [31:0]           cos_angle,
    output logic                  cos_clk_en,
    output logic                  cos_reset,
    input  logic [31:0]           cos_result,
    output logic                  resp_valid,
    output logic [ID_W-1:0]       resp_id,
    output logic [31:0]           resp_data,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // Round-robin pick: search starts one past the previous winner and
    // wraps. Iterating from the farthest candidate down to the nearest lets
    // the nearest requesting slot overwrite the result last, so it wins.
    // Returns {found, id}.
    // ------------------------------------------------------------------
    function automatic logic [ID_W:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [ID_W-1:0]    ptr
    );
        logic [ID_W:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (valid[idx[ID_W-1:0]]) begin
                pick = {1'b1, idx[ID_W-1:0]};
            end
        end
        return pick;
    endfunction

    // State
    logic                 cos_reset_r;
    logic [ID_W-1:0]      last_grant_r;
    logic [LATENCY:0]     tag_valid_r;
    logic [ID_W-1:0]      tag_id_r [0:LATENCY];
    logic                 resp_valid_r;
    logic [ID_W-1:0]      resp_id_r;
    logic [31:0]          resp_data_r;

    // Combinational
    logic                 grant_found_s;
    logic [ID_W-1:0]      grant_id_s;
    logic                 issue_ok_s;
    logic                 accept_s;
    logic [NUM_REQ-1:0]   req_ready_s;
    logic [31:0]          cos_angle_s;
    logic                 pipe_occupied_s;
    logic                 busy_s;

    // Arbitration: pick the next requester and qualify it against the
    // datapath reset and flush, which both block new issues.
    always_comb begin
        {grant_found_s, grant_id_s} = rr_pick(req_valid, last_grant_r);
        issue_ok_s                  = ~cos_reset_r & ~flush;
        accept_s                    = grant_found_s & issue_ok_s;
    end

    // One-hot ready toward the winner, only when the issue really happens.
    always_comb begin
        req_ready_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready_s[i] = accept_s & (grant_id_s == ID_W'(i));
        end
    end

    // Angle mux: AND-OR over the one-hot ready, so nothing granted gives 0.
    always_comb begin
        cos_angle_s = 32'h0000_0000;
        for (int i = 0; i < NUM_REQ; i++) begin
            cos_angle_s = cos_angle_s | (req_angle[32*i +: 32] & {32{req_ready_s[i]}});
        end
    end

    // Datapath occupancy: entries 0..LATENCY-2 mean data still sits inside
    // the datapath registers; the final datapath stage is being read out
    // this cycle, so it does not need another enabled edge.
    always_comb begin
        pipe_occupied_s = 1'b0;
        for (int k = 0; k < LATENCY - 1; k++) begin
            pipe_occupied_s = pipe_occupied_s | tag_valid_r[k];
        end
    end

    // Anything anywhere in the tag pipe counts as in flight.
    always_comb begin
        busy_s = |tag_valid_r;
    end

    // Datapath reset: high out of reset, then follows flush by one edge so
    // a flush wipes the datapath and blocks issue for the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cos_reset_r <= 1'b1;
        end else begin
            cos_reset_r <= flush;
        end
    end

    // Round-robin pointer: moves only on a completed handshake.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= '0;
        end else if (accept_s) begin
            last_grant_r <= grant_id_s;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Tag pipe valids: shift the accept flag along with the datapath; a
    // flush drops every in-flight operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_valid_r <= '0;
        end else if (flush) begin
            tag_valid_r <= '0;
        end else begin
            tag_valid_r <= {tag_valid_r[LATENCY-1:0], accept_s};
        end
    end

    // Tag pipe IDs: shift unconditionally; the valids decide what they mean.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k <= LATENCY; k++) begin
                tag_id_r[k] <= '0;
            end
        end else begin
            tag_id_r[0] <= grant_id_s;
            for (int k = 1; k <= LATENCY; k++) begin
                tag_id_r[k] <= tag_id_r[k-1];
            end
        end
    end

    // Response register: capture the datapath result when the aligned tag
    // says it is valid, unless a flush is aborting that operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_r <= 1'b0;
            resp_id_r    <= '0;
            resp_data_r  <= 32'h0000_0000;
        end else if (tag_valid_r[LATENCY-1] && !flush) begin
            resp_valid_r <= 1'b1;
            resp_id_r    <= tag_id_r[LATENCY-1];
            resp_data_r  <= cos_result;
        end else begin
            resp_valid_r <= 1'b0;
            resp_id_r    <= resp_id_r;
            resp_data_r  <= resp_data_r;
        end
    end

    // Output wiring
    assign req_ready  = req_ready_s;
    assign cos_angle  = cos_angle_s;
    assign cos_clk_en = accept_s | pipe_occupied_s;
    assign cos_reset  = cos_reset_r;
    assign resp_valid = resp_valid_r;
    assign resp_id    = resp_id_r;
    assign resp_data  = resp_data_r;
    assign busy       = busy_s;

endmodule

// File: tb/tb_cordic_cos_scheduler.sv
// Self-checking bench for cordic_cos_scheduler. A stand-in datapath delays
// the issued angle by LATENCY enabled cycles and returns angle ^ 3F800000
// (so angle 0 gives 1.0). A transaction-level model (queue of in-flight
// operations, round-robin pointer) predicts every output every cycle, and
// logged streams are compared against hand-computed literal sequences.

module tb_cordic_cos_scheduler;
    localparam int NUM_REQ = 4;
    localparam int LATENCY = 2;
    localparam int ID_W    = $clog2(NUM_REQ);

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_angle;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  flush;
    logic [31:0]           cos_angle;
    logic                  cos_clk_en;
    logic                  cos_reset;
    logic [31:0]           cos_result;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_data;
    logic                  busy;

    always #5 clk = ~clk;

    cordic_cos_scheduler #(.NUM_REQ(NUM_REQ), .LATENCY(LATENCY), .ID_W(ID_W)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_angle(req_angle),
        .req_ready(req_ready), .flush(flush), .cos_angle(cos_angle),
        .cos_clk_en(cos_clk_en), .cos_reset(cos_reset), .cos_result(cos_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
    );

    // Stand-in datapath
    logic [31:0] dp [LATENCY];
    always @(posedge clk) begin
        if (cos_reset || !cos_clk_en) begin
            for (int k = 0; k < LATENCY; k++) dp[k] <= 32'h0;
        end else begin
            dp[0] <= cos_angle;
            for (int k = 1; k < LATENCY; k++) dp[k] <= dp[k-1];
        end
    end
    assign cos_result = dp[LATENCY-1] ^ 32'h3F80_0000;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Requesters
    int          pend [NUM_REQ];
    int          seq  [NUM_REQ];
    logic [31:0] ang_base [NUM_REQ];
    logic [NUM_REQ-1:0] hs_mask = '0;

    task automatic drive();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_valid[i]          = (pend[i] > 0);
            req_angle[32*i +: 32] = ang_base[i] + 32'(seq[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin
                pend[i] = pend[i] - 1;
                seq[i]  = seq[i] + 1;
            end
        end
        drive();
    endtask

    // Observation logs
    int          acc_id_log[$];
    int          acc_cyc_log[$];
    int          resp_id_log[$];
    int          resp_cyc_log[$];
    logic [31:0] resp_data_log[$];
    int          en_log[$];
    int          cr_log[$];

    task automatic clear_logs();
        acc_id_log.delete(); acc_cyc_log.delete();
        resp_id_log.delete(); resp_cyc_log.delete(); resp_data_log.delete();
        en_log.delete(); cr_log.delete();
    endtask

    // Transaction model
    typedef struct { int t; int id; logic [31:0] ang; } op_t;
    op_t             mq[$];
    int              m_ptr = 0;
    logic            m_cos_reset = 1'b1;
    logic [ID_W-1:0] m_rid = '0;
    logic [31:0]     m_rdata = 32'h0;

    // Compare process: mid-cycle, predict and check every output.
    always @(negedge clk) begin
        logic               exp_rv;
        logic               exp_acc;
        int                 exp_gid;
        int                 idx;
        logic [NUM_REQ-1:0] exp_ready;
        logic [31:0]        exp_angle;
        logic               exp_en;
        logic               exp_busy;

        hs_mask = req_valid & req_ready;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hs_mask[i]) begin acc_id_log.push_back(i); acc_cyc_log.push_back(cyc); end
        end
        if (resp_valid) begin
            resp_id_log.push_back(int'(resp_id)); resp_cyc_log.push_back(cyc);
            resp_data_log.push_back(resp_data);
        end
        if (cos_clk_en) en_log.push_back(cyc);
        if (cos_reset && reset) cr_log.push_back(cyc);

        exp_rv = 1'b0; exp_acc = 1'b0; exp_gid = 0; exp_ready = '0;
        exp_angle = 32'h0; exp_en = 1'b0; exp_busy = 1'b0;
        if (!reset) begin
            mq.delete();
            m_ptr = 0; m_cos_reset = 1'b1; m_rid = '0; m_rdata = 32'h0;
        end else begin
            exp_busy = (mq.size() != 0);
            if (mq.size() != 0 && mq[0].t + LATENCY + 1 == cyc) begin
                exp_rv  = 1'b1;
                m_rid   = ID_W'(mq[0].id);
                m_rdata = mq[0].ang ^ 32'h3F80_0000;
                void'(mq.pop_front());
            end
            foreach (mq[k]) begin
                if (cyc - mq[k].t <= LATENCY - 1) exp_en = 1'b1;
            end
            if (!m_cos_reset && !flush) begin
                for (int k = NUM_REQ; k >= 1; k--) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (req_valid[idx[ID_W-1:0]]) begin exp_acc = 1'b1; exp_gid = idx; end
                end
            end
            if (exp_acc) begin
                exp_ready[exp_gid[ID_W-1:0]] = 1'b1;
                exp_angle = req_angle[32*exp_gid +: 32];
                exp_en    = 1'b1;
            end
        end

        chk("req_ready",  32'(req_ready),  32'(exp_ready));
        chk("cos_angle",  cos_angle,       exp_angle);
        chk("cos_clk_en", 32'(cos_clk_en), 32'(exp_en));
        chk("cos_reset",  32'(cos_reset),  32'(m_cos_reset));
        chk("busy",       32'(busy),       32'(exp_busy));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_id",    32'(resp_id),    32'(m_rid));
        chk("resp_data",  resp_data,       m_rdata);

        if (reset) begin
            if (flush) mq.delete();
            if (exp_acc) begin
                mq.push_back('{t: cyc, id: exp_gid, ang: exp_angle});
                m_ptr = exp_gid;
            end
            m_cos_reset = flush;
        end
    end

    int t0, r, b0, f0, s0, rel, p0;
    int fair_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};
    int tail_seq [4] = '{1, 2, 3, 0};

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = '0; req_angle = '0;
        ang_base[0] = 32'h3F00_0000; ang_base[1] = 32'h3E80_0100;
        ang_base[2] = 32'h0000_0000; ang_base[3] = 32'h4049_0FDB;
        for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 0; seq[i] = 0; end
        drive();
        repeat (3) step();
        reset = 1'b1;

        // Idle after reset
        clear_logs();
        repeat (20) step();
        chk("idle_acc_count",  32'(acc_id_log.size()),  32'd0);
        chk("idle_resp_count", 32'(resp_id_log.size()), 32'd0);
        chk("idle_en_count",   32'(en_log.size()),      32'd0);

        // Single request from requester 2, angle 0
        clear_logs();
        pend[2] = 1; drive(); t0 = cyc;
        repeat (6) step();
        chk("single_acc_count", 32'(acc_id_log.size()), 32'd1);
        if (acc_id_log.size() == 1) begin
            chk("single_acc_id",  32'(acc_id_log[0]),  32'd2);
            chk("single_acc_cyc", 32'(acc_cyc_log[0]), 32'(t0));
        end
        chk("single_resp_count", 32'(resp_id_log.size()), 32'd1);
        if (resp_id_log.size() == 1) begin
            chk("single_resp_id",   32'(resp_id_log[0]),  32'd2);
            chk("single_resp_data", resp_data_log[0],     32'h3F80_0000);
            chk("single_latency",   32'(resp_cyc_log[0]), 32'(t0 + 3));
        end
        chk("single_en_count", 32'(en_log.size()), 32'd2);
        if (en_log.size() == 2) begin
            chk("single_en_first", 32'(en_log[0]), 32'(t0));
            chk("single_en_last",  32'(en_log[1]), 32'(t0 + 1));
        end

        // Fairness after a fresh reset: pointer 0 -> 1,2,3,0,...
        #1 reset = 1'b0;
        step(); step();
        reset = 1'b1; r = cyc;
        clear_logs();
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 2;
        drive();
        repeat (14) step();
        chk("fair_acc_count",  32'(acc_id_log.size()),  32'd8);
        chk("fair_resp_count", 32'(resp_id_log.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < acc_id_log.size()) begin
                chk("fair_acc_id",  32'(acc_id_log[k]),  32'(fair_seq[k]));
                chk("fair_acc_cyc", 32'(acc_cyc_log[k]), 32'(r + 1 + k));
            end
            if (k < resp_id_log.size()) begin
                chk("fair_resp_id",  32'(resp_id_log[k]),  32'(fair_seq[k]));
                chk("fair_resp_cyc", 32'(resp_cyc_log[k]), 32'(r + 4 + k));
            end
        end

        // Burst of 8 from requester 0
        clear_logs();
        pend[0] = 8; drive(); b0 = cyc;
        repeat (12) step();
        chk("burst_resp_count", 32'(resp_id_log.size()), 32'd8);
        for (int k = 0; k < resp_id_log.size(); k++) begin
            chk("burst_resp_cyc", 32'(resp_cyc_log[k]), 32'(b0 + 3 + k));
            chk("burst_resp_id",  32'(resp_id_log[k]),  32'd0);
        end
        chk("burst_en_count", 32'(en_log.size()), 32'd9);
        for (int k = 0; k < en_log.size(); k++) begin
            chk("burst_en_cyc", 32'(en_log[k]), 32'(b0 + k));
        end

        // Flush with two operations in flight
        clear_logs();
        pend[1] = 2; drive(); f0 = cyc;
        step(); step();
        flush = 1'b1; pend[3] = 1; drive();
        step();
        flush = 1'b0;
        repeat (6) step();
        chk("flush_acc_count", 32'(acc_id_log.size()), 32'd3);
        if (acc_id_log.size() == 3) begin
            chk("flush_acc_id0",  32'(acc_id_log[0]),  32'd1);
            chk("flush_acc_cyc1", 32'(acc_cyc_log[1]), 32'(f0 + 1));
            chk("flush_acc_id2",  32'(acc_id_log[2]),  32'd3);
            chk("flush_acc_cyc2", 32'(acc_cyc_log[2]), 32'(f0 + 4));
        end
        chk("flush_resp_count", 32'(resp_id_log.size()), 32'd1);
        if (resp_id_log.size() == 1) begin
            chk("flush_resp_id",  32'(resp_id_log[0]),  32'd3);
            chk("flush_resp_cyc", 32'(resp_cyc_log[0]), 32'(f0 + 7));
        end
        chk("flush_cr_count", 32'(cr_log.size()), 32'd1);
        if (cr_log.size() == 1) chk("flush_cr_cyc", 32'(cr_log[0]), 32'(f0 + 3));

        // Asynchronous reset in the middle of a burst
        clear_logs();
        pend[0] = 6; drive(); s0 = cyc;
        step(); step(); step();
        #1 reset = 1'b0;
        step(); step();
        reset = 1'b1; rel = cyc;
        repeat (8) step();
        chk("rst_acc_count",  32'(acc_id_log.size()),  32'd6);
        if (acc_id_log.size() == 6) begin
            chk("rst_acc_pre",  32'(acc_cyc_log[2]), 32'(s0 + 2));
            chk("rst_acc_post", 32'(acc_cyc_log[3]), 32'(rel + 1));
        end
        chk("rst_resp_count", 32'(resp_id_log.size()), 32'd3);
        if (resp_id_log.size() == 3) chk("rst_resp_first", 32'(resp_cyc_log[0]), 32'(rel + 4));

        // Long idle, then pointer must still sit at 0
        clear_logs();
        repeat (20) step();
        chk("idle2_acc_count",  32'(acc_id_log.size()),  32'd0);
        chk("idle2_resp_count", 32'(resp_id_log.size()), 32'd0);
        chk("idle2_en_count",   32'(en_log.size()),      32'd0);
        for (int i = 0; i < NUM_REQ; i++) pend[i] = 1;
        drive(); p0 = cyc;
        repeat (8) step();
        chk("ptr_acc_count", 32'(acc_id_log.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
            if (k < acc_id_log.size()) begin
                chk("ptr_acc_id",  32'(acc_id_log[k]),  32'(tail_seq[k]));
                chk("ptr_acc_cyc", 32'(acc_cyc_log[k]), 32'(p0 + k));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_cos_scheduler.md
Name: cordic_cos_scheduler

Overview:
- Shares one pipelined cosine CORDIC datapath among NUM_REQ requesters.
- Round-robin arbiter issues at most one angle per cycle into the datapath.
- Tracks each in-flight operation's requester ID through a tag pipe aligned to the datapath latency, then returns each result to the correct requester.
- Drives the datapath's clk_en and reset. clk_en is gated off only when the pipeline is empty, because deasserting it clears in-flight data.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, datapath register stages: angle applied in cycle t gives a valid cos_result in cycle t+LATENCY.
- ID_W, $clog2(NUM_REQ), width of the requester ID.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_angle  input  32*NUM_REQ  per-requester IEEE-754 single angle; slice i is bits [32*i+:32].
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- flush  input  1  synchronous abort of all in-flight operations.
- cos_angle  output  32  angle to the datapath.
- cos_clk_en  output  1  datapath clock enable.
- cos_reset  output  1  datapath synchronous reset, active-high.
- cos_result  input  32  datapath result.
- resp_valid  output  1  one-cycle response strobe.
- resp_id  output  ID_W  requester index of the response.
- resp_data  output  32  cosine result.
- busy  output  1  high while any operation is in flight.

Behaviour:
- Reset values (reset low): resp_valid=0, resp_id=0, resp_data=0, tag pipe valids=0, rr pointer=0, cos_reset=1.
  - cos_reset is registered; it deasserts on the first clk edge after reset rises.
  - No request is accepted while cos_reset=1.
- Arbitration:
  - Search starts at requester (last_grant+1) mod NUM_REQ and wraps around; the first requester with req_valid=1 is granted.
  - req_ready[g] is combinational, is high only for the granted requester, and is 0 while cos_reset=1 or flush=1.
  - last_grant updates only on an accepted handshake (req_valid & req_ready).
  - With no requests, the pointer holds.
- Issue:
  - cos_angle = req_angle slice of the granted requester. When nothing is granted, cos_angle=0.
  - Requesters hold req_angle stable while req_valid is high and the request has not been accepted.
  - Throughput: one accept per cycle sustained.
- Tag pipe: LATENCY+1 entries of {valid, id}.
  - Entry 0 loads {accept, grant_id} each cycle; entry k loads entry k-1.
  - Entry LATENCY-1 valid means cos_result is valid this cycle.
- Response:
  - When entry LATENCY-1 is valid, resp_data <= cos_result, resp_id <= its id, resp_valid <= 1.
  - Otherwise resp_valid <= 0, and resp_data/resp_id hold.
  - Total latency: accept in cycle t gives resp_valid in cycle t+LATENCY+1.
  - Responses leave in issue order. There is no backpressure; the consumer must take every response.
- cos_clk_en = accept OR any tag-pipe valid within entries 0..LATENCY-2.
  - Held high whenever data sits in datapath registers.
  - Low when idle (datapath registers clear, which is harmless when empty).
- busy = OR of all tag-pipe valids.
- Flush:
  - In the cycle flush=1, no accept occurs.
  - At the next edge, all tag valids clear, cos_reset is registered high for one cycle, and no resp_valid is produced for aborted operations.
  - A response already registered in that cycle still completes (resp_valid was set in the prior edge).
  - Accepting resumes after cos_reset returns low.
  - flush during reset has no effect.
- Reset mid-operation: all state clears immediately (asynchronous); no response is produced for lost operations.
- Simultaneous accept and final-stage response in the same cycle are independent and both take effect.

Test Plan:
- Single request: req_valid[2]=1, angle 32'h00000000, accepted in cycle 5 -> resp_valid=1 in cycle 8 with resp_id=2 and resp_data equal to cos_result sampled in cycle 7 (≈32'h3F800000, within 2^-20 relative); cos_clk_en high in cycles 5-6, low after.
- Fairness: all four req_valid held high from cycle 0 after reset, pointer=0 -> grants in order 1,2,3,0,1,...; one accept per cycle; resp_id stream 1,2,3,0 starting 3 cycles after the first accept.
- Back-to-back burst of 8 accepts from requester 0 only -> 8 consecutive resp_valid cycles; cos_clk_en continuously high; busy falls 3 cycles after the last accept.
- Flush with 2 operations in flight (accepts at cycles 10 and 11, flush at 12) -> no resp_valid at 13 or 14; cos_reset=1 at cycle 13; req_ready=0 at 12-13; a new accept is possible at cycle 14.
- Asynchronous reset asserted mid-burst between clock edges -> resp_valid, busy and valids are 0 immediately; cos_reset=1; after release, the first accept happens no earlier than the second edge.
- Idle gating: no requests for 20 cycles -> cos_clk_en=0, busy=0, resp_valid=0 throughout; pointer unchanged.
